traffic_phase_ctrl: RTL
=======================

Name: traffic_phase_ctrl

Overview:
Parametrised successor to the fixed two-group intersection sequencer. It sequences N_PHASE signal groups round-robin through GREEN -> YELLOW -> ALL_RED. Each phase has its own runtime-adjustable green and yellow durations. It supports night flashing and frozen configuration modes. It sits between the 1 s tick / key-pulse conditioning logic and the lamp drivers, 7-segment BCD path and 74HC595 shifter.

Parameters:
N_PHASE, 4, number of signal groups (2..8).
CNT_W, 11, width of duration counters and config registers.
GREEN_DEF, 8, reset green duration, in ticks, for every phase.
YEL_DEF, 6, reset yellow duration, in ticks, for every phase.
ALLRED_T, 1, all-red clearance ticks between phases; 0 = no clearance state.

Ports:
clk  in  1  system clock (12 MHz).
rst  in  1  asynchronous, active-high reset.
tick  in  1  single-cycle pulse, 1 Hz, synchronous to clk.
mode  in  2  00 run, 01 night, 10 set green, 11 set yellow.
key_plus  in  1  single-cycle increment pulse.
key_sub  in  1  single-cycle decrement pulse.
cfg_phase  in  $clog2(N_PHASE)  phase whose duration is edited in set modes.
lamp_r  out  N_PHASE  red lamp per phase.
lamp_y  out  N_PHASE  yellow lamp per phase.
lamp_g  out  N_PHASE  green lamp per phase.
cur_phase  out  $clog2(N_PHASE)  phase currently owning the right-of-way.
state_o  out  2  00 NIGHT, 01 GREEN, 10 YELLOW, 11 ALL_RED.
remain  out  CNT_W  ticks left in current state; in set modes, the edited register value.
phase_done  out  1  one-cycle pulse on the YELLOW->ALL_RED or YELLOW->GREEN exit.

Behaviour:
- Reset: state ALL_RED, cur_phase 0, counter ALLRED_T (min 1), all lamp_r=1, lamp_y=0, lamp_g=0, phase_done 0, all green regs GREEN_DEF, all yellow regs YEL_DEF, blink 0.
- Lamps are registered, 1-cycle latency from the state change. Non-active phases are always red.
- Counter loads the duration on state entry and decrements on tick in run mode. When tick arrives with counter==1, the FSM takes the next state in that same cycle, so a duration D lasts exactly D ticks.
- GREEN(p) -> YELLOW(p) -> ALL_RED -> GREEN((p+1) mod N_PHASE). If ALLRED_T=0, YELLOW(p) goes directly to GREEN(p+1).
- Durations are loaded from the register of the phase being entered, sampled at the load cycle. Edits made mid-state take effect at the next load.
- Night (mode 01), from any state, immediate: state NIGHT, counter 0, cur_phase 0. lamp_y all = blink; blink toggles on each tick. r/g all 0.
- Leaving night to run: ALL_RED for max(ALLRED_T,1) ticks, then GREEN(0).
- Set modes (10/11): FSM and counter frozen, lamps hold their last value, tick ignored. key_plus / key_sub adjust the selected register.
- Adjustment saturates: minimum 1, maximum 2^CNT_W-1. Simultaneous plus and sub = no change. A cfg_phase >= N_PHASE is ignored.
- Mode change from set to run resumes the frozen state with the counter unchanged.
- Reset mid-operation discards edited durations (registers return to defaults).

Optional Feature:
DEMAND_SKIP_EN. When defined, add input demand[N_PHASE]. On leaving ALL_RED (or YELLOW if ALLRED_T=0), the next phase is the nearest index after cur_phase with demand=1; the search wraps and includes cur_phase itself. If no demand bit is set, cur_phase repeats its GREEN. Without the macro, the sequence is strict round-robin and there is no demand port.

Decomposition:
- Package traffic_pkg holds: the state encodings (NIGHT/GREEN/YELLOW/ALL_RED), the mode codes (RUN/NIGHT/SET_G/SET_Y), and the lamp-pattern constants.
- Sub-module phase_cfg_regs: N_PHASE x 2 duration register file with saturating plus/minus and a read port indexed by phase. This sub-module is natural and is used for both the load path and the display path.

Test Plan:
- Reset, run, defaults, N_PHASE=4, ALLRED_T=1 -> phase 0 GREEN for 8 ticks, YELLOW 6, ALL_RED 1, then phase 1 GREEN. Phase 3 wraps to phase 0. phase_done pulses once per phase.
- mode=10, cfg_phase=2, 3x key_plus -> remain=11. Return to run -> phase 2 green lasts 11 ticks, others stay 8.
- mode=11, 10x key_sub from 6 -> register saturates at 1. Yellow lasts 1 tick. Plus and sub in the same cycle -> value unchanged.
- Night during GREEN(1) -> next cycle all r/g=0; lamp_y toggles each tick. Return to run -> 1 ALL_RED tick, then GREEN(0).
- Assert rst mid-YELLOW after edits -> outputs are asynchronously at reset values; durations are 8/6 again.
- DEMAND_SKIP_EN, demand=4'b1001, in GREEN(0) -> next is GREEN(3). demand=0 -> GREEN(0) repeats.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the phase sequencer: FSM states, operating modes and lamp patterns.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_NIGHT   = 2'b00,
      ST_GREEN   = 2'b01,
      ST_YELLOW  = 2'b10,
      ST_ALL_RED = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'b00,
      MODE_NIGHT = 2'b01,
      MODE_SET_G = 2'b10,
      MODE_SET_Y = 2'b11
   } mode_e;

   typedef struct packed {
      logic r;
      logic y;
      logic g;
   } lamp_t;

   localparam lamp_t LAMP_OFF = '{r: 1'b0, y: 1'b0, g: 1'b0};
   localparam lamp_t LAMP_RED = '{r: 1'b1, y: 1'b0, g: 1'b0};
   localparam lamp_t LAMP_YEL = '{r: 1'b0, y: 1'b1, g: 1'b0};
   localparam lamp_t LAMP_GRN = '{r: 1'b0, y: 1'b0, g: 1'b1};

   // Lamp pattern of one signal group given the FSM state and whether it owns the right-of-way.
   function automatic lamp_t lamp_of(input state_e st, input logic active, input logic blink);
      lamp_t l;
      l = LAMP_RED;
      if (st == ST_NIGHT) begin
         l   = LAMP_OFF;
         l.y = blink;
      end else if (active) begin
         case (st)
            ST_GREEN:  l = LAMP_GRN;
            ST_YELLOW: l = LAMP_YEL;
            default:   l = LAMP_RED;
         endcase
      end
      return l;
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl_cfg_regs.sv
// Per-phase green/yellow duration registers with saturating key adjustment and one read port.
module phase_cfg_regs
   import traffic_pkg::*;
#(
   parameter int unsigned N_PHASE   = 4,
   parameter int unsigned CNT_W     = 11,
   parameter int unsigned GREEN_DEF = 8,
   parameter int unsigned YEL_DEF   = 6,
   parameter int unsigned PH_W      = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             edit_en,
   input  logic             edit_yel,
   input  logic [PH_W-1:0]  edit_phase,
   input  logic             key_plus,
   input  logic             key_sub,
   input  logic [PH_W-1:0]  rd_phase,
   output logic [CNT_W-1:0] rd_green_c,
   output logic [CNT_W-1:0] rd_yellow_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] green_q [N_PHASE];
   logic [CNT_W-1:0] green_d [N_PHASE];
   logic [CNT_W-1:0] yel_q   [N_PHASE];
   logic [CNT_W-1:0] yel_d   [N_PHASE];
   logic             step_c;

   function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] v, input logic up);
      logic [CNT_W-1:0] res;
      if (up) res = (v == CNT_MAX) ? v : v + CNT_ONE;
      else    res = (v <= CNT_ONE) ? CNT_ONE : v - CNT_ONE;
      return res;
   endfunction

   // Plus and sub together cancel; an out-of-range phase index matches no register.
   assign step_c = edit_en && (key_plus ^ key_sub);

   always_comb begin
      for (int p = 0; p < int'(N_PHASE); p++) begin
         green_d[p] = green_q[p];
         yel_d[p]   = yel_q[p];
         if (step_c && (edit_phase == PH_W'(p))) begin
            if (edit_yel) yel_d[p]   = sat_step(yel_q[p], key_plus);
            else          green_d[p] = sat_step(green_q[p], key_plus);
         end
      end
   end

   always_comb begin
      rd_green_c  = '0;
      rd_yellow_c = '0;
      for (int p = 0; p < int'(N_PHASE); p++) begin
         if (rd_phase == PH_W'(p)) begin
            rd_green_c  = green_q[p];
            rd_yellow_c = yel_q[p];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < int'(N_PHASE); p++) begin
            green_q[p] <= CNT_W'(GREEN_DEF);
            yel_q[p]   <= CNT_W'(YEL_DEF);
         end
      end else begin
         for (int p = 0; p < int'(N_PHASE); p++) begin
            green_q[p] <= green_d[p];
            yel_q[p]   <= yel_d[p];
         end
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase round-robin signal sequencer with night flashing and frozen edit modes.
// Define DEMAND_SKIP_EN to add a demand[] input that skips phases without demand.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned N_PHASE   = 4,
   parameter int unsigned CNT_W     = 11,
   parameter int unsigned GREEN_DEF = 8,
   parameter int unsigned YEL_DEF   = 6,
   parameter int unsigned ALLRED_T  = 1,
   localparam int unsigned PH_W     = (N_PHASE > 1) ? $clog2(N_PHASE) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic [1:0]         mode,
   input  logic               key_plus,
   input  logic               key_sub,
   input  logic [PH_W-1:0]    cfg_phase,
`ifdef DEMAND_SKIP_EN
   input  logic [N_PHASE-1:0] demand,
`endif
   output logic [N_PHASE-1:0] lamp_r,
   output logic [N_PHASE-1:0] lamp_y,
   output logic [N_PHASE-1:0] lamp_g,
   output logic [PH_W-1:0]    cur_phase,
   output logic [1:0]         state_o,
   output logic [CNT_W-1:0]   remain,
   output logic               phase_done
);

   localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'((ALLRED_T == 0) ? 1 : ALLRED_T);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   remain_q, remain_d;
   logic [PH_W-1:0]    cur_q, cur_d;
   logic               blink_q, blink_d;
   logic               start_q, start_d;
   logic               done_q, done_d;
   logic [N_PHASE-1:0] r_q, r_d, y_q, y_d, g_q, g_d;

   mode_e              mode_c;
   logic               set_mode_c;
   logic               expire_c;
   logic [PH_W-1:0]    nxt_phase_c;
   logic [PH_W-1:0]    rd_phase_c;
   logic [CNT_W-1:0]   rd_green_c, rd_yellow_c;

   assign mode_c     = mode_e'(mode);
   assign set_mode_c = mode[1];
   assign expire_c   = tick && (cnt_q <= CNT_W'(1));

   // After reset or night the first green goes to cur_phase itself (start_q), otherwise the next one.
   always_comb begin : next_phase_sel
`ifdef DEMAND_SKIP_EN
      logic            found;
      logic [PH_W-1:0] cand;
      found       = 1'b0;
      cand        = cur_q;
      nxt_phase_c = cur_q;
      for (int i = 0; i < int'(N_PHASE); i++) begin
         cand = PH_W'((int'(cur_q) + i + (start_q ? 0 : 1)) % int'(N_PHASE));
         if (!found && demand[cand]) begin
            found       = 1'b1;
            nxt_phase_c = cand;
         end
      end
`else
      nxt_phase_c = start_q ? cur_q
                  : ((cur_q == PH_W'(N_PHASE - 1)) ? '0 : cur_q + PH_W'(1));
`endif
   end

   // Shared read port: edited phase while frozen, otherwise the phase whose duration loads next.
   assign rd_phase_c = set_mode_c ? cfg_phase
                     : ((state_q == ST_GREEN) ? cur_q : nxt_phase_c);

   phase_cfg_regs #(
      .N_PHASE   (N_PHASE),
      .CNT_W     (CNT_W),
      .GREEN_DEF (GREEN_DEF),
      .YEL_DEF   (YEL_DEF),
      .PH_W      (PH_W)
   ) u_cfg (
      .clk         (clk),
      .rst         (rst),
      .edit_en     (set_mode_c),
      .edit_yel    (mode_c == MODE_SET_Y),
      .edit_phase  (cfg_phase),
      .key_plus    (key_plus),
      .key_sub     (key_sub),
      .rd_phase    (rd_phase_c),
      .rd_green_c  (rd_green_c),
      .rd_yellow_c (rd_yellow_c)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      blink_d = blink_q;
      start_d = start_q;
      done_d  = 1'b0;

      case (mode_c)
         MODE_NIGHT: begin
            state_d = ST_NIGHT;
            cnt_d   = '0;
            cur_d   = '0;
            blink_d = (state_q == ST_NIGHT) ? (blink_q ^ tick) : 1'b0;
         end
         MODE_RUN: begin
            blink_d = 1'b0;
            case (state_q)
               ST_NIGHT: begin
                  state_d = ST_ALL_RED;
                  cnt_d   = AR_LOAD;
                  cur_d   = '0;
                  start_d = 1'b1;
               end
               ST_GREEN: begin
                  if (expire_c) begin
                     state_d = ST_YELLOW;
                     cnt_d   = rd_yellow_c;
                  end else if (tick) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
               ST_YELLOW: begin
                  if (expire_c) begin
                     done_d = 1'b1;
                     if (ALLRED_T == 0) begin
                        state_d = ST_GREEN;
                        cur_d   = nxt_phase_c;
                        cnt_d   = rd_green_c;
                        start_d = 1'b0;
                     end else begin
                        state_d = ST_ALL_RED;
                        cnt_d   = AR_LOAD;
                     end
                  end else if (tick) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
               default: begin
                  if (expire_c) begin
                     state_d = ST_GREEN;
                     cur_d   = nxt_phase_c;
                     cnt_d   = rd_green_c;
                     start_d = 1'b0;
                  end else if (tick) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
            endcase
         end
         default: ;
      endcase
   end

   // Lamps follow the registered state one cycle later and hold while frozen.
   always_comb begin
      lamp_t lp;
      lp  = LAMP_OFF;
      r_d = r_q;
      y_d = y_q;
      g_d = g_q;
      if (!set_mode_c) begin
         for (int p = 0; p < int'(N_PHASE); p++) begin
            lp     = lamp_of(state_q, cur_q == PH_W'(p), blink_q);
            r_d[p] = lp.r;
            y_d[p] = lp.y;
            g_d[p] = lp.g;
         end
      end
   end

   always_comb begin
      remain_d = cnt_d;
      if (set_mode_c) remain_d = (mode_c == MODE_SET_Y) ? rd_yellow_c : rd_green_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_ALL_RED;
         cnt_q    <= AR_LOAD;
         remain_q <= AR_LOAD;
         cur_q    <= '0;
         blink_q  <= 1'b0;
         start_q  <= 1'b1;
         done_q   <= 1'b0;
         r_q      <= '1;
         y_q      <= '0;
         g_q      <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         remain_q <= remain_d;
         cur_q    <= cur_d;
         blink_q  <= blink_d;
         start_q  <= start_d;
         done_q   <= done_d;
         r_q      <= r_d;
         y_q      <= y_d;
         g_q      <= g_d;
      end
   end

   assign lamp_r     = r_q;
   assign lamp_y     = y_q;
   assign lamp_g     = g_q;
   assign cur_phase  = cur_q;
   assign state_o    = state_q;
   assign remain     = remain_q;
   assign phase_done = done_q;

endmodule
